// File: rtl/adat_rx_if.sv
// Serial-in / symbol-out bundle for adat_rx.
// master drives the bit stream; slave is the receiver.
interface adat_rx_if #(
    parameter int SYM_W = 4,
    parameter int ERR_W = 8
);
    logic             adat_in;
    logic             data_change;
    logic             locked;
    logic [SYM_W-1:0] sym_out;
    logic             sym_valid;
    logic             frame_start;
    logic [ERR_W-1:0] bit_err_cnt;

    modport master (
        output adat_in,
        output data_change,
        input  locked,
        input  sym_out,
        input  sym_valid,
        input  frame_start,
        input  bit_err_cnt
    );

    modport slave (
        input  adat_in,
        input  data_change,
        output locked,
        output sym_out,
        output sym_valid,
        output frame_start,
        output bit_err_cnt
    );
endinterface

// File: rtl/adat_rx.sv
// adat_rx: frame synchroniser (HUNT/VERIFY/LOCKED) for the 28-bit test frame, with aligned symbol output.
// Define ADAT_RX_ERRCNT_EN to build the saturating bit_err_cnt; otherwise it is tied to 0.
module adat_rx #(
    parameter logic [27:0] PATTERN = 28'h6CC1555,
    parameter int          SYM_W   = 4,
    parameter int          CONFIRM = 2,
    parameter int          MAX_ERR = 2,
    parameter int          ERR_W   = 8
) (
    input  logic     clock,
    input  logic     reset,
    adat_rx_if.slave bus
);
    localparam int                FC_W      = $clog2(CONFIRM + 1);
    localparam int                SB        = $clog2(SYM_W);
    localparam logic [4:0]        LAST_POS  = 5'd27;
    localparam logic [4:0]        FULL      = 5'd28;
    localparam logic [4:0]        MAX_ERR_L = 5'(MAX_ERR);
    localparam logic [FC_W-1:0]   CONFIRM_L = FC_W'(CONFIRM);
    localparam logic [SB-1:0]     SYM_LAST  = SB'(SYM_W - 1);

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [27:0]      sr_q, sr_d;
    logic [4:0]       fill_q, fill_d;
    logic [4:0]       pos_q, pos_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic [4:0]       ferr_q, ferr_d;
    logic [SYM_W-2:0] symsr_q, symsr_d;
    logic [SYM_W-1:0] sym_q, sym_d;
    logic             locked_q, locked_d;
    logic             sv_q, sv_d;
    logic             fs_q, fs_d;

    logic             mism;
    logic             pos_last;
    logic [4:0]       pos_wrap;
    logic [FC_W-1:0]  fcnt_inc;
    logic [SYM_W-1:0] sym_word;
    logic [4:0]       frame_err;
    logic             frame_bad;
    logic             sym_last;
    logic             err_inc;

    assign mism      = bus.adat_in ^ PATTERN[LAST_POS - pos_q];
    assign pos_last  = (pos_q == LAST_POS);
    assign pos_wrap  = pos_last ? 5'd0 : pos_q + 5'd1;
    assign fcnt_inc  = fcnt_q + 1'b1;
    assign sym_word  = {symsr_q, bus.adat_in};
    assign sym_last  = (pos_q[SB-1:0] == SYM_LAST);
    // Per-frame mismatch count restarts at pos 0 and includes the bit being accepted.
    assign frame_err = ((pos_q == 5'd0) ? 5'd0 : ferr_q) + {4'd0, mism};
    assign frame_bad = pos_last && (frame_err > MAX_ERR_L);

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        fill_d  = fill_q;
        pos_d   = pos_q;
        fcnt_d  = fcnt_q;
        ferr_d  = ferr_q;
        symsr_d = symsr_q;
        sym_d   = sym_q;
        sv_d    = 1'b0;
        fs_d    = 1'b0;
        err_inc = 1'b0;

        if (bus.data_change) begin
            sr_d = {sr_q[26:0], bus.adat_in};
            if (fill_q != FULL) begin
                fill_d = fill_q + 5'd1;
            end

            unique case (state_q)
                HUNT: begin
                    if ((sr_d == PATTERN) && (fill_d == FULL)) begin
                        state_d = VERIFY;
                        pos_d   = 5'd0;
                        fcnt_d  = '0;
                    end
                end
                VERIFY: begin
                    pos_d = pos_wrap;
                    if (mism) begin
                        state_d = HUNT;
                        pos_d   = 5'd0;
                        err_inc = 1'b1;
                    end else if (pos_last) begin
                        fcnt_d = fcnt_inc;
                        if (fcnt_inc == CONFIRM_L) begin
                            state_d = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    pos_d   = pos_wrap;
                    err_inc = mism;
                    fs_d    = (pos_q == 5'd0);
                    ferr_d  = frame_err;
                    // Symbols are aligned to pos, so stale partial bits are always shifted out before use.
                    symsr_d = sym_word[SYM_W-2:0];
                    if (sym_last && !frame_bad) begin
                        sym_d = sym_word;
                        sv_d  = 1'b1;
                    end
                    if (frame_bad) begin
                        state_d = HUNT;
                        pos_d   = 5'd0;
                    end
                end
                default: begin
                    state_d = HUNT;
                    pos_d   = 5'd0;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= HUNT;
            sr_q     <= '0;
            fill_q   <= '0;
            pos_q    <= '0;
            fcnt_q   <= '0;
            ferr_q   <= '0;
            symsr_q  <= '0;
            sym_q    <= '0;
            locked_q <= 1'b0;
            sv_q     <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            fill_q   <= fill_d;
            pos_q    <= pos_d;
            fcnt_q   <= fcnt_d;
            ferr_q   <= ferr_d;
            symsr_q  <= symsr_d;
            sym_q    <= sym_d;
            locked_q <= locked_d;
            sv_q     <= sv_d;
            fs_q     <= fs_d;
        end
    end

`ifdef ADAT_RX_ERRCNT_EN
    logic [ERR_W-1:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (err_inc && (err_q != '1)) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.bit_err_cnt = err_q;
`else
    logic unused_err_inc;
    assign unused_err_inc  = err_inc;
    assign bus.bit_err_cnt = '0;
`endif

    assign bus.locked      = locked_q;
    assign bus.sym_out     = sym_q;
    assign bus.sym_valid   = sv_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_adat_rx.sv
// Bench for adat_rx: frame-level vector table, hand sequences for lock/unlock/reset corners,
// and a randomized stream checked every clock against a queue-based reference model.
module tb_adat_rx;
    localparam logic [27:0] PAT     = 28'h6CC1555;
    localparam int          SYM_W   = 4;
    localparam int          CONFIRM = 2;
    localparam int          MAX_ERR = 2;
    localparam int          ERR_W   = 8;
`ifdef ADAT_RX_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif
    localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    adat_rx_if #(.SYM_W(SYM_W), .ERR_W(ERR_W)) bus ();

    adat_rx #(
        .PATTERN(PAT),
        .SYM_W  (SYM_W),
        .CONFIRM(CONFIRM),
        .MAX_ERR(MAX_ERR),
        .ERR_W  (ERR_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: received-bit history plus frame bookkeeping.
    bit   hist[$];
    int   m_mode, m_pos, m_frames, m_ferr, m_err, m_sym;
    logic m_locked, m_sv, m_fs;

    logic       last_lk, last_sv, last_fs;
    logic [3:0] last_so;

    typedef struct {
        logic [27:0] mask;
        logic        exp_locked;
        int          exp_nsym;
        logic [3:0]  exp_sym1;
        int          exp_errs;
    } vec_t;
    vec_t vecs[7];
    logic [3:0] seq[7];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit window_matches();
        if (hist.size() != 28) return 1'b0;
        for (int i = 0; i < 28; i++) begin
            if (hist[i] != PAT[27 - i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int last_bits();
        int v = 0;
        for (int i = 0; i < SYM_W; i++) begin
            v = (v << 1) | int'(hist[hist.size() - SYM_W + i]);
        end
        return v;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_mode = M_HUNT; m_pos = 0; m_frames = 0; m_ferr = 0; m_err = 0; m_sym = 0;
        m_locked = 1'b0; m_sv = 1'b0; m_fs = 1'b0;
    endtask

    task automatic model_strobe(input bit b);
        bit bad;
        bit lose;
        bad = (m_mode != M_HUNT) && (b != PAT[27 - m_pos]);
        hist.push_back(b);
        if (hist.size() > 28) void'(hist.pop_front());
        m_sv = 1'b0;
        m_fs = 1'b0;
        if (bad && (m_err < (1 << ERR_W) - 1)) m_err++;
        case (m_mode)
            M_HUNT: begin
                if (window_matches()) begin
                    m_mode = M_VERIFY; m_pos = 0; m_frames = 0;
                end
            end
            M_VERIFY: begin
                if (bad) begin
                    m_mode = M_HUNT; m_pos = 0;
                end else begin
                    if (m_pos == 27) begin
                        m_frames++;
                        if (m_frames == CONFIRM) m_mode = M_LOCKED;
                    end
                    m_pos = (m_pos + 1) % 28;
                end
            end
            default: begin
                m_fs = (m_pos == 0);
                if (m_pos == 0) m_ferr = 0;
                m_ferr += int'(bad);
                lose = (m_pos == 27) && (m_ferr > MAX_ERR);
                if ((m_pos % SYM_W == SYM_W - 1) && !lose) begin
                    m_sym = last_bits();
                    m_sv  = 1'b1;
                end
                m_pos = (m_pos + 1) % 28;
                if (lose) begin
                    m_mode = M_HUNT; m_pos = 0;
                end
            end
        endcase
        m_locked = (m_mode == M_LOCKED);
    endtask

    task automatic compare_all();
        check("locked", bus.locked, m_locked);
        check("sym_out", bus.sym_out, m_sym);
        check("sym_valid", bus.sym_valid, m_sv);
        check("frame_start", bus.frame_start, m_fs);
        check("bit_err_cnt", bus.bit_err_cnt, ERRCNT ? m_err : 0);
    endtask

    task automatic tick(input logic ds, input logic d);
        bus.data_change = ds;
        bus.adat_in     = d;
        @(posedge clock);
        if (ds && reset) begin
            model_strobe(d);
        end else begin
            m_sv = 1'b0;
            m_fs = 1'b0;
        end
        #1 compare_all();
    endtask

    task automatic send(input logic b, input int gap);
        tick(1'b1, b);
        last_lk = bus.locked;
        last_sv = bus.sym_valid;
        last_so = bus.sym_out;
        last_fs = bus.frame_start;
        for (int g = 0; g < gap; g++) tick(1'b0, 1'($urandom));
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        model_reset();
        tick(1'b0, 1'b0);
        #2 reset = 1'b1;
    endtask

    task automatic async_reset();
        #2 reset = 1'b0;
        model_reset();
        #1;
        check("arst_locked", bus.locked, 0);
        check("arst_sym_out", bus.sym_out, 0);
        check("arst_sym_valid", bus.sym_valid, 0);
        check("arst_frame_start", bus.frame_start, 0);
        check("arst_err", bus.bit_err_cnt, 0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        #2 reset = 1'b1;
    endtask

    task automatic send_clean_frames(input int n);
        for (int s = 0; s < n * 28; s++) send(PAT[27 - (s % 28)], 0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nsym, nfs, nsv_pre;
        logic [3:0] sym1;
        int sp, rate;

        vecs[0] = '{28'h0000000, 1'b1, 7, 4'hC, 0};
        vecs[1] = '{28'h0400000, 1'b1, 7, 4'h8, 1};
        vecs[2] = '{28'h0900000, 1'b1, 7, 4'h5, 2};
        vecs[3] = '{28'h0000003, 1'b1, 7, 4'hC, 2};
        vecs[4] = '{28'hE000000, 1'b0, 6, 4'hC, 3};
        vecs[5] = '{28'h0020003, 1'b0, 6, 4'hC, 3};
        vecs[6] = '{28'hFFFFFFF, 1'b0, 6, 4'h3, 28};
        seq = '{4'h6, 4'hC, 4'hC, 4'h1, 4'h5, 4'h5, 4'h5};

        // Reset state, including a strobe while reset is low.
        bus.adat_in = 1'b0;
        bus.data_change = 1'b0;
        model_reset();
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        check("rst_locked", bus.locked, 0);
        check("rst_sym_out", bus.sym_out, 0);
        check("rst_sym_valid", bus.sym_valid, 0);
        check("rst_frame_start", bus.frame_start, 0);
        check("rst_err", bus.bit_err_cnt, 0);
        #2 reset = 1'b1;

        // Generator timing: strobe every 16 clocks, lock on strobe 84.
        do_reset();
        for (int s = 1; s <= 84; s++) begin
            send(PAT[27 - ((s - 1) % 28)], 15);
            if (s == 83) check("gen_locked_s83", last_lk, 0);
            if (s == 84) check("gen_locked_s84", last_lk, 1);
        end
        nsym = 0;
        nfs = 0;
        for (int k = 0; k < 56; k++) begin
            send(PAT[27 - (k % 28)], 15);
            if (last_sv) begin
                check("gen_symbol", last_so, seq[nsym % 7]);
                nsym++;
            end
            if (last_fs) begin
                check("gen_fs_pos", k % 28, 0);
                nfs++;
            end
        end
        check("gen_nsym", nsym, 14);
        check("gen_nfs", nfs, 2);
        check("gen_err", bus.bit_err_cnt, 0);

        // Frame-level table: lock cleanly, then one frame with the given bit flips.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            send_clean_frames(3);
            nsym = 0;
            sym1 = 4'h0;
            for (int p = 0; p < 28; p++) begin
                send(PAT[27 - p] ^ vecs[v].mask[27 - p], 0);
                if (last_sv) begin
                    if (nsym == 1) sym1 = last_so;
                    nsym++;
                end
            end
            check($sformatf("vec%0d_locked", v), last_lk, vecs[v].exp_locked);
            check($sformatf("vec%0d_nsym", v), nsym, vecs[v].exp_nsym);
            check($sformatf("vec%0d_sym1", v), sym1, vecs[v].exp_sym1);
            check($sformatf("vec%0d_err", v), bus.bit_err_cnt, ERRCNT ? vecs[v].exp_errs : 0);
        end

        // Lock loss on a 3-error frame, then relock 56 strobes after the next clean frame.
        do_reset();
        send_clean_frames(3);
        for (int p = 0; p < 28; p++) send(PAT[27 - p] ^ (p < 3), 0);
        check("loss_locked", last_lk, 0);
        nsv_pre = 0;
        for (int s = 1; s <= 84; s++) begin
            send(PAT[27 - ((s - 1) % 28)], 0);
            if (last_sv && !last_lk) nsv_pre++;
            if (s == 83) check("relock_s83", last_lk, 0);
            if (s == 84) check("relock_s84", last_lk, 1);
        end
        check("relock_no_sv", nsv_pre, 0);

        // Error in the first VERIFY frame: back to HUNT, lock at strobe 140.
        do_reset();
        for (int s = 1; s <= 140; s++) begin
            send(PAT[27 - ((s - 1) % 28)] ^ (s == 32), 0);
            if (s == 139) check("verr_s139", last_lk, 0);
            if (s == 140) check("verr_s140", last_lk, 1);
        end

        // Reset mid-symbol while locked, resume mid-frame.
        do_reset();
        send_clean_frames(3);
        send(PAT[27], 0);
        send(PAT[26], 0);
        async_reset();
        nsv_pre = 0;
        for (int s = 1; s <= 110; s++) begin
            send(PAT[27 - ((s + 1) % 28)], 0);
            if (last_sv) nsv_pre++;
            if (s == 109) check("rrel_s109", last_lk, 0);
            if (s == 110) check("rrel_s110", last_lk, 1);
        end
        check("rrel_no_sv", nsv_pre, 0);

        // Saturation: two errors in every frame for 130 frames.
        do_reset();
        send_clean_frames(3);
        for (int f = 0; f < 130; f++) begin
            for (int p = 0; p < 28; p++) send(PAT[27 - p] ^ ((p == 5) || (p == 20)), 0);
        end
        check("sat_locked", last_lk, 1);
        check("sat_err", bus.bit_err_cnt, ERRCNT ? 255 : 0);

        // Randomized stream with varying error rate, gaps and occasional resets.
        do_reset();
        sp = $urandom_range(0, 27);
        rate = 0;
        for (int s = 0; s < 5000; s++) begin
            if (s % 500 == 0) begin
                case ($urandom_range(0, 3))
                    0: rate = 0;
                    1: rate = 5;
                    2: rate = 40;
                    default: rate = 150;
                endcase
            end
            if ($urandom_range(0, 1499) == 0) async_reset();
            send(PAT[27 - sp] ^ 1'($urandom_range(0, 999) < rate), $urandom_range(0, 2));
            sp = (sp + 1) % 28;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
